// File: rtl/vproc_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// vproc_hazard_scoreboard
//
// Purpose:
//   Vector dispatch hazard scoreboard. Each decoded instruction arrives with
//   a 32-bit vreg write mask and a 32-bit vreg read mask. The instruction is
//   held at the input until it is free of RAW, WAW and WAR hazards against
//   every in-flight instruction and its ID is not already in use. It is then
//   issued through a one-entry output register. Execution units release an
//   instruction's read mask (read clear) and later retire it entirely (write
//   clear), which frees its ID.
//
// Ports:
//   clk_i, async_rst_ni         clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     decoded instruction handshake (in_ready_o is
//                               combinational on in_id_i and the masks)
//   in_id_i                     instruction ID, indexes the tracking table
//   in_wr_hazards_i             vregs written by the instruction
//   in_rd_vregs_i               vregs read by the instruction
//   in_payload_i                opaque payload forwarded to the units
//   out_valid_o / out_ready_i   issue handshake towards the units
//   out_id_o, out_payload_o     issued instruction
//   rd_clear_valid_i/_id_i      operands of an ID have been read
//   wr_clear_valid_i/_id_i      an ID has retired its writes (frees the ID)
//   pending_wr_o, pending_rd_o  OR of all registered write / read masks
// ---------------------------------------------------------------------------
module vproc_hazard_scoreboard #(
    parameter int unsigned INSTR_ID_W     = 3,
    parameter int unsigned PAYLOAD_W      = 64,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,

    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [INSTR_ID_W-1:0] in_id_i,
    input  logic [31:0]           in_wr_hazards_i,
    input  logic [31:0]           in_rd_vregs_i,
    input  logic [PAYLOAD_W-1:0]  in_payload_i,

    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [INSTR_ID_W-1:0] out_id_o,
    output logic [PAYLOAD_W-1:0]  out_payload_o,

    input  logic                  rd_clear_valid_i,
    input  logic [INSTR_ID_W-1:0] rd_clear_id_i,
    input  logic                  wr_clear_valid_i,
    input  logic [INSTR_ID_W-1:0] wr_clear_id_i,

    output logic [31:0]           pending_wr_o,
    output logic [31:0]           pending_rd_o
);

    localparam int DEPTH = 1 << INSTR_ID_W;

    localparam logic [PAYLOAD_W-1:0] PAYLOAD_RST =
        DONT_CARE_ZERO ? {PAYLOAD_W{1'b0}} : {PAYLOAD_W{1'bx}};

    logic [DEPTH-1:0]       r_busy;
    logic [31:0]            r_wr_mask [DEPTH];
    logic [31:0]            r_rd_mask [DEPTH];

    logic                   r_out_valid;
    logic [INSTR_ID_W-1:0]  r_out_id;
    logic [PAYLOAD_W-1:0]   r_out_payload;

    logic [31:0]            w_pending_wr;
    logic [31:0]            w_pending_rd;
    logic                   w_stall;
    logic                   w_in_ready;
    logic                   w_accept;

    // Pending masks come from registered state only, so a clear issued this
    // cycle cannot unblock an instruction before the next cycle.
    always_comb begin
        w_pending_wr = '0;
        w_pending_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pending_wr = w_pending_wr | r_wr_mask[i];
            w_pending_rd = w_pending_rd | r_rd_mask[i];
        end
    end

    // ID collision, RAW, WAW and WAR respectively.
    assign w_stall = r_busy[in_id_i]
                   | (|(in_rd_vregs_i   & w_pending_wr))
                   | (|(in_wr_hazards_i & w_pending_wr))
                   | (|(in_wr_hazards_i & w_pending_rd));

    assign w_in_ready = (!r_out_valid || out_ready_i) && !w_stall;
    assign w_accept   = in_valid_i && w_in_ready;

    // Tracking table. An accept only targets a non-busy entry and clears only
    // act on busy entries, so the two never collide on the same index.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_wr_mask[i] <= '0;
                r_rd_mask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i]) begin
                    // Write clear retires the entry and subsumes a read clear
                    // to the same ID.
                    if (wr_clear_valid_i && (wr_clear_id_i == INSTR_ID_W'(i))) begin
                        r_busy[i]    <= 1'b0;
                        r_wr_mask[i] <= '0;
                        r_rd_mask[i] <= '0;
                    end else if (rd_clear_valid_i && (rd_clear_id_i == INSTR_ID_W'(i))) begin
                        r_rd_mask[i] <= '0;
                    end
                end else if (w_accept && (in_id_i == INSTR_ID_W'(i))) begin
                    r_busy[i]    <= 1'b1;
                    r_wr_mask[i] <= in_wr_hazards_i;
                    r_rd_mask[i] <= in_rd_vregs_i;
                end
            end
        end
    end

    // One-entry issue register; reloads back-to-back when the current entry
    // is consumed in the same cycle as a new accept.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_out_valid   <= 1'b0;
            r_out_id      <= '0;
            r_out_payload <= PAYLOAD_RST;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_id      <= in_id_i;
            r_out_payload <= in_payload_i;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign in_ready_o    = w_in_ready;
    assign out_valid_o   = r_out_valid;
    assign out_id_o      = r_out_id;
    assign out_payload_o = r_out_payload;
    assign pending_wr_o  = w_pending_wr;
    assign pending_rd_o  = w_pending_rd;

endmodule
